// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised serial sequence detector.
// The functions are evaluated only on constants and build the KMP next-state table.
package seq_det_pkg;

    localparam int MAX_SEQ_LEN = 16;

    function automatic int seq_state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(input logic [15:0] pattern, input int len);
        int  res;
        bit  ok;
        res = 0;
        for (int j = len - 1; j > 0; j--) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                if (pattern[len-1-t] != pattern[j-1-t]) ok = 1'b0;
            end
            if (ok && res == 0) res = j;
        end
        return res;
    endfunction

    // From state k (k bits matched), consume bit b and return the longest
    // prefix of the pattern that is a suffix of the bits seen so far.
    function automatic int next_state(input logic [15:0] pattern, input int len,
                                      input int k, input logic b);
        int   res;
        int   jmax;
        int   idx;
        bit   ok;
        logic sb;
        res  = 0;
        jmax = (k + 1 < len) ? k + 1 : len;
        for (int j = jmax; j > 0; j--) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                idx = k + 1 - j + t;
                sb  = (idx == k) ? b : pattern[len-1-idx];
                if (sb != pattern[len-1-t]) ok = 1'b0;
            end
            if (ok && res == 0) res = j;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter; a clear on the same edge as an increment wins.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial sequence detector with a constant KMP next-state table,
// run-time overlap selection, input-valid qualification and a saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0] PATTERN = 5'b11011,
    parameter int                 CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in,
    input  logic                           in_valid,
    input  logic                           overlap_en,
    input  logic                           cnt_clr,
    output logic                           out,
    output logic [$clog2(SEQ_LEN+1)-1:0]   state_o,
    output logic [CNT_W-1:0]               match_count
);

    localparam int             SW     = seq_state_w(SEQ_LEN);
    localparam int             ROWS   = 2 ** SW;
    localparam logic [15:0]    PAT16  = 16'(PATTERN);
    localparam int             F      = border_len(PAT16, SEQ_LEN);
    localparam logic [SW-1:0]  FULL_S = SW'(SEQ_LEN);
    localparam logic [SW-1:0]  F_S    = SW'(F);

    logic [SW-1:0] nxt_tbl [ROWS][2];
    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] cur_s;
    logic          det_enter;

    // Rows beyond SEQ_LEN are unreachable; the full state is remapped before lookup.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k < SEQ_LEN) begin : g_live
                assign nxt_tbl[k][b] = SW'(next_state(PAT16, SEQ_LEN, k, 1'(b)));
            end else begin : g_dead
                assign nxt_tbl[k][b] = '0;
            end
        end
    end

    always_comb begin
        cur_s     = state_q;
        state_d   = state_q;
        det_enter = 1'b0;
        if (state_q == FULL_S) begin
            cur_s = overlap_en ? F_S : '0;
        end
        if (in_valid) begin
            state_d   = nxt_tbl[cur_s][in];
            det_enter = (state_d == FULL_S);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign out     = (state_q == FULL_S);
    assign state_o = state_q;

    seq_det_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (det_enter),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus stream and are
// compared each cycle against a brute-force history model through a scoreboard queue.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       din;
    logic       in_valid;
    logic       overlap_en;
    logic       cnt_clr;

    logic       out0, out1, out2;
    logic [2:0] state0, state1, state2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    int checks = 0;
    int errors = 0;
    int pulses0 = 0;
    int pulses2 = 0;

    typedef struct {
        int st;
        int o;
        int cnt;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    // Reference model state, one slot per DUT instance.
    logic [15:0] m_pat  [3];
    int          m_len  [3];
    int          m_cmax [3];
    logic [63:0] m_hist [3];
    int          m_hlen [3];
    int          m_st   [3];
    int          m_cnt  [3];

    seq_detector_param u_dut0 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .out(out0), .state_o(state0), .match_count(cnt0)
    );

    seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b11011), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .out(out1), .state_o(state1), .match_count(cnt1)
    );

    seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .out(out2), .state_o(state2), .match_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_state(input int d);
        int  jmax;
        bit  ok;
        jmax = (m_hlen[d] < m_len[d]) ? m_hlen[d] : m_len[d];
        for (int j = jmax; j > 0; j--) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                if (m_hist[d][t] != m_pat[d][m_len[d]-j+t]) ok = 1'b0;
            end
            if (ok) return j;
        end
        return 0;
    endfunction

    task automatic model_step(input int d, input logic b, input logic v, input logic ov,
                              input logic clr, input logic r);
        if (r) begin
            m_hlen[d] = 0;
            m_hist[d] = '0;
            m_st[d]   = 0;
            m_cnt[d]  = 0;
        end else begin
            if (v) begin
                if (m_st[d] == m_len[d] && !ov) m_hlen[d] = 0;
                m_hist[d] = {m_hist[d][62:0], b};
                if (m_hlen[d] < 64) m_hlen[d]++;
                m_st[d] = model_state(d);
                if (m_st[d] == m_len[d] && m_cnt[d] < m_cmax[d]) m_cnt[d]++;
            end
            if (clr) m_cnt[d] = 0;
        end
    endtask

    task automatic compare_one(input int d, input int st, input int o, input int cnt);
        exp_t e;
        int   have;
        have = (d == 0) ? exp_q0.size() : (d == 1) ? exp_q1.size() : exp_q2.size();
        if (have == 0) begin
            check_eq($sformatf("sb_empty_d%0d", d), 0, 1);
        end else begin
            case (d)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check_eq($sformatf("state_d%0d", d), st,  e.st);
            check_eq($sformatf("out_d%0d",   d), o,   e.o);
            check_eq($sformatf("count_d%0d", d), cnt, e.cnt);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic ov, input logic clr,
                        input logic r);
        exp_t e;
        din        = b;
        in_valid   = v;
        overlap_en = ov;
        cnt_clr    = clr;
        rst        = r;
        for (int d = 0; d < 3; d++) begin
            model_step(d, b, v, ov, clr, r);
            e.st  = m_st[d];
            e.o   = (m_st[d] == m_len[d]) ? 1 : 0;
            e.cnt = m_cnt[d];
            case (d)
                0:       exp_q0.push_back(e);
                1:       exp_q1.push_back(e);
                default: exp_q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        if (out0) pulses0++;
        if (out2) pulses2++;
        compare_one(0, int'(state0), int'(out0), int'(cnt0));
        compare_one(1, int'(state1), int'(out1), int'(cnt1));
        compare_one(2, int'(state2), int'(out2), int'(cnt2));
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic ov);
        for (int i = 0; i < n; i++) step(bits[n-1-i], 1'b1, ov, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        m_pat[0] = 16'b11011; m_len[0] = 5; m_cmax[0] = 255;
        m_pat[1] = 16'b11011; m_len[1] = 5; m_cmax[1] = 3;
        m_pat[2] = 16'b1010;  m_len[2] = 4; m_cmax[2] = 255;
        for (int d = 0; d < 3; d++) begin
            m_hist[d] = '0; m_hlen[d] = 0; m_st[d] = 0; m_cnt[d] = 0;
        end
        rst = 1'b1; din = 1'b0; in_valid = 1'b0; overlap_en = 1'b0; cnt_clr = 1'b0;

        do_reset();
        do_reset();
        check_eq("rst_state", int'(state0), 0);
        check_eq("rst_out",   int'(out0),   0);
        check_eq("rst_count", int'(cnt0),   0);

        // Non-overlapping 11011011
        pulses0 = 0;
        send_bits(16'b11011011, 8, 1'b0);
        check_eq("nonovl_pulses", pulses0,      1);
        check_eq("nonovl_state",  int'(state0), 2);
        check_eq("nonovl_count",  int'(cnt0),   1);

        // Overlapping 11011011
        do_reset();
        pulses0 = 0;
        send_bits(16'b11011, 5, 1'b1);
        check_eq("ovl_state_b5", int'(state0), 5);
        send_bits(16'b011, 3, 1'b1);
        check_eq("ovl_pulses", pulses0,      2);
        check_eq("ovl_state",  int'(state0), 5);
        check_eq("ovl_count",  int'(cnt0),   2);

        // Valid gap after the third bit
        do_reset();
        send_bits(16'b110, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'(i & 1), 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("gap_hold", int'(state0), 3);
        end
        send_bits(16'b11, 2, 1'b0);
        check_eq("gap_out",   int'(out0), 1);
        check_eq("gap_count", int'(cnt0), 1);

        // Mid-pattern reset
        do_reset();
        send_bits(16'b1101, 4, 1'b0);
        do_reset();
        check_eq("midrst_state", int'(state0), 0);
        check_eq("midrst_out",   int'(out0),   0);
        check_eq("midrst_count", int'(cnt0),   0);
        send_bits(16'b1, 1, 1'b0);
        check_eq("midrst_next", int'(state0), 1);

        // Saturation on the 2-bit counter, then clear coinciding with a detection
        do_reset();
        send_bits(16'b11011, 5, 1'b1);
        check_eq("sat_c1", int'(cnt1), 1);
        send_bits(16'b011, 3, 1'b1);
        check_eq("sat_c2", int'(cnt1), 2);
        send_bits(16'b011, 3, 1'b1);
        check_eq("sat_c3", int'(cnt1), 3);
        send_bits(16'b011, 3, 1'b1);
        check_eq("sat_c4", int'(cnt1), 3);
        send_bits(16'b011, 3, 1'b1);
        check_eq("sat_c5", int'(cnt1), 3);
        send_bits(16'b01, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("clr_count", int'(cnt1), 0);
        check_eq("clr_out",   int'(out1), 1);

        // 1010 pattern, overlapping then non-overlapping
        do_reset();
        pulses2 = 0;
        send_bits(16'b101010, 6, 1'b1);
        check_eq("p1010_ovl_count",  int'(cnt2), 2);
        check_eq("p1010_ovl_pulses", pulses2,    2);
        do_reset();
        pulses2 = 0;
        send_bits(16'b101010, 6, 1'b0);
        check_eq("p1010_nov_count",  int'(cnt2), 1);
        check_eq("p1010_nov_pulses", pulses2,    1);

        // Randomised traffic, including valid gaps, mode flips, clears and resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
